// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one full-adder cell LSB-first across WIDTH-bit operands.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf_o.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout_o,
    output logic             ovf_o
`else
    output logic             cout_o
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_sh_q, res_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    // The shared full-adder cell.
    logic cell_s, cell_co;
    assign cell_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign cell_co = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start_i) begin
                    state_d  = StRun;
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    carry_d  = cin_i;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end
            StRun: begin
                carry_d  = cell_co;
                res_sh_d = {cell_s, res_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                    sum_d   = {cell_s, res_sh_q[WIDTH-1:1]};
                    cout_d  = cell_co;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on the final bit.
                    ovf_d   = cell_co ^ carry_q;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy_o = (state_q == StRun);
    assign done_o = (state_q == StDone);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed table-driven bench for serial_adder_ctrl at WIDTH=4.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .sum_o   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout_o  (cout),
        .ovf_o   (ovf)
`else
        .cout_o  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: present operands, let the next posedge accept them.
    task automatic apply_start(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Four busy cycles with sum held, then the done cycle carrying the result.
    task automatic expect_run(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("busy_run", {31'b0, busy}, 32'd1);
            chk("done_run", {31'b0, done}, 32'd0);
            chk("sum_hold", {28'b0, sum}, {28'b0, last_sum});
        end
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd1);
        chk("busy_done", {31'b0, busy}, 32'd0);
        chk("sum", {28'b0, sum}, {28'b0, v.exp_sum});
        chk("cout", {31'b0, cout}, {31'b0, v.exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", {31'b0, ovf}, {31'b0, v.exp_ovf});
`endif
        last_sum = v.exp_sum;
    endtask

    vec_t vecs[7];
    logic [W-1:0] ha[20];
    logic [W-1:0] hb[20];
    logic         hc[20];

    initial begin
        //            a        b        cin   sum      cout  ovf
        vecs[0] = '{4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0, 1'b1};
        vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[3] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[4] = '{4'b0011, 4'b0100, 1'b1, 4'b1000, 1'b0, 1'b1};
        vecs[5] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[6] = '{4'b1001, 4'b0110, 1'b0, 4'b1111, 1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        last_sum = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {28'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif

        // Table of isolated operations.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            apply_start(vecs[i].a, vecs[i].b, vecs[i].cin);
            expect_run(vecs[i]);
            @(negedge clk);
            chk("done_one_cycle", {31'b0, done}, 32'd0);
            chk("idle_busy", {31'b0, busy}, 32'd0);
        end

        // start held high: accepts at edges 0,5,10,15 with fresh operands every cycle.
        for (int c = 0; c < 20; c++) begin
            ha[c] = W'($urandom);
            hb[c] = W'($urandom);
            hc[c] = 1'($urandom);
        end
        @(negedge clk);
        for (int c = 0; c < 21; c++) begin
            if (c > 0) begin
                chk("held_busy", {31'b0, busy},
                    {31'b0, (((c - 1) % 5) != 4) ? 1'b1 : 1'b0});
                chk("held_done", {31'b0, done},
                    {31'b0, (((c - 1) % 5) == 4) ? 1'b1 : 1'b0});
                if (((c - 1) % 5) == 4) begin
                    logic [W:0] tot;
                    tot = {1'b0, ha[c-5]} + {1'b0, hb[c-5]} + {{W{1'b0}}, hc[c-5]};
                    chk("held_sum", {28'b0, sum}, {28'b0, tot[W-1:0]});
                    chk("held_cout", {31'b0, cout}, {31'b0, tot[W]});
                    last_sum = tot[W-1:0];
                end
            end
            if (c < 20) begin
                a = ha[c];
                b = hb[c];
                cin = hc[c];
                start = 1'b1;
                @(negedge clk);
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("held_idle", {31'b0, busy | done}, 32'd0);

        // Ensure a nonzero sum is visible before the abort.
        @(negedge clk);
        apply_start(vecs[6].a, vecs[6].b, vecs[6].cin);
        expect_run(vecs[6]);

        // Reset during the 2nd RUN cycle.
        @(negedge clk);
        apply_start(4'b0101, 4'b0110, 1'b0);
        @(negedge clk);
        chk("pre_abort_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_sum", {28'b0, sum}, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done | busy}, 32'd0);
        end
        apply_start(vecs[0].a, vecs[0].b, vecs[0].cin);
        expect_run(vecs[0]);

        // Start issued in the DONE cycle: back-to-back with sum held meanwhile.
        apply_start(vecs[4].a, vecs[4].b, vecs[4].cin);
        expect_run(vecs[4]);
        apply_start(vecs[5].a, vecs[5].b, vecs[5].cin);
        expect_run(vecs[5]);
        @(negedge clk);
        chk("final_idle", {31'b0, busy | done}, 32'd0);
        chk("final_sum_hold", {28'b0, sum}, {28'b0, vecs[5].exp_sum});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder cell across two WIDTH-bit operands, LSB first, one bit per clock. It sits between a requester using a start/done handshake and the shared full-adder datapath. It owns the operand shift registers, the carry flop, the bit counter and the result register, so one adder cell can serve an arbitrary word width.

## Interface
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- cin  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while RUN.
- done  out  1  one-cycle pulse; high while in DONE.
- sum  out  WIDTH  registered result; holds its value until the next completion.
- cout  out  1  registered final carry-out.
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- One clock domain. Reset is asynchronous and active-low.
- States:
  - IDLE (reset state).
  - RUN.
  - DONE.
- Transitions:
  - IDLE, start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, res_sh<=0; go to RUN.
  - IDLE, start=0: stay in IDLE.
  - RUN, every cycle: the full-adder cell sees ci=carry, a=a_sh[0], b=b_sh[0].
    - carry<=cell cout.
    - res_sh<={cell S, res_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by one.
    - cnt<=cnt+1.
  - RUN, cnt==WIDTH-1: go to DONE. On the same edge:
    - sum<={S, res_sh[WIDTH-1:1]}.
    - cout<=cell cout.
    - ovf<=cell cout XOR carry.
  - DONE, start=1: reload exactly as in IDLE and go to RUN. Back-to-back operation is supported.
  - DONE, start=0: go to IDLE.
- start is ignored in RUN. An in-flight operation is never disturbed. No queueing of ignored requests.
- a, b and cin are don't-care except on the accepting edge.
- cnt width is $clog2(WIDTH). It never wraps within an operation.
- Arithmetic is unsigned modulo 2^WIDTH; the carry out of the MSB goes to cout.
- Reset mid-operation aborts the operation immediately. All state and outputs clear; no done pulse is produced.

## Timing
- Reset values:
  - state=IDLE.
  - busy=0, done=0.
  - sum=0, cout=0, ovf=0.
  - All internal registers 0.
- Start accepted at edge k:
  - busy=1 from k+1 through k+WIDTH.
  - Bit i is computed during cycle k+1+i and registered at edge k+1+i.
  - sum, cout and ovf update at edge k+WIDTH.
  - done=1 and busy=0 during the cycle after edge k+WIDTH.
- Latency from the accepting edge to done high: WIDTH edges. Issue interval: WIDTH+1 cycles.
- busy and done are never high simultaneously. Both decode directly from the state register.
- Outputs are glitch-free registers or direct state decodes. There is no combinational path from any input to any output.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Port ovf exists.
  - ovf = (carry into MSB) XOR (carry out of MSB), registered with sum.
  - Reset value 0.
- SERIAL_ADDER_OVF_EN undefined:
  - Port ovf and its flop are absent.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=4.
- After reset release, before any start: busy=0, done=0, sum=0, cout=0.
- a=4'b0111, b=4'b0101, cin=0, start pulsed -> busy for 4 cycles, then done for 1 cycle with sum=4'b1100, cout=0, ovf=1.
- a=4'b1111, b=4'b0001, cin=0 -> sum=4'b0000, cout=1, ovf=0. Then a=4'b0000, b=4'b0000, cin=1 -> sum=4'b0001, cout=0.
- start held high continuously with new operands each cycle -> starts are accepted only in IDLE/DONE:
  - Issue interval is exactly 5 cycles.
  - Each result matches the operands captured on its accepting edge.
- rst_n asserted for 1 cycle during the 2nd RUN cycle -> all outputs go to 0 immediately and no done pulse follows. A new start afterwards completes correctly.
- start pulsed in the DONE cycle -> RUN re-entered on the next edge (busy=1). sum keeps its previous value until the new completion.
